timer_irq_source: RTL
=====================

Name: timer_irq_source

Overview:
Programmable down-counting timer peripheral that raises an interrupt request toward one IRQ/IACK/IEND lane of the interrupt controller. It sits directly upstream of the controller and drives one peripheral slot: IRQ[0] or IRQ[1], consuming IACK/IEND for that slot. The CPU configures it through a small synchronous register port. Expiries that occur while an interrupt is still pending or in service are queued as a single pending flag.

Parameters:
- WIDTH, 16, width of the LOAD register, the down-counter and the register data bus.
- PRE_W, 8, width of the PRESCALE register and the prescaler counter.
- OVR_W, 8, width of the overrun counter (used only with the optional feature).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- WE  in  1  register write strobe, sampled on the rising edge of CLK.
- ADDR  in  2  register select: 0 LOAD, 1 CTRL, 2 PRESCALE, 3 STATUS.
- WDATA  in  WIDTH  write data.
- RDATA  out  WIDTH  combinational read of the register selected by ADDR.
- IRQ  out  1  interrupt request to the controller.
- IACK  in  1  acknowledge from the controller for this slot.
- IEND  in  1  end-of-service from the controller for this slot; a level held until the CPU drops it.

Behaviour:
- Reset: all registers, the counter, the prescaler, the pending flag and the overrun count go to 0. State goes to IDLE and IRQ = 0. The same applies to a reset in any state, including mid-handshake.
- Registers:
  - LOAD holds the reload value.
  - CTRL: bit0 EN, bit1 PERIODIC; other bits read 0.
  - PRESCALE is PRE_W bits, zero-extended on read.
  - STATUS is read-only: bit0 pending, bit1 busy (state != IDLE), bits[15:8] overrun count (0 without the macro). A write to STATUS clears the overrun count.
- Prescaler: counts 0..PRESCALE. A tick occurs on a cycle where prescaler == PRESCALE and EN = 1; the prescaler then returns to 0. PRESCALE = 0 gives a tick every cycle. The prescaler is frozen while EN = 0.
- Enable:
  - A write to CTRL with EN going 0->1 sets cnt <= LOAD and prescaler <= 0 on that edge.
  - A write with EN = 1 while EN is already 1 updates PERIODIC only; there is no reload.
  - Writing EN = 0 freezes the counter. It does not cancel the pending flag or an in-progress handshake.
- Count: on a tick, if cnt == 1 the timer expires.
  - PERIODIC = 1: cnt <= LOAD.
  - PERIODIC = 0: cnt <= 0 and EN <= 0.
  - Otherwise, if cnt > 1, cnt <= cnt - 1.
  - cnt == 0 with EN = 1 (LOAD = 0) holds: there is no expiry.
- LOAD writes while running take effect at the next reload or enable.
- Expiry sets pending on the same edge. If pending is already 1 and not being cleared, the expiry counts as an overrun.
- FSM (IRQ = 1 only in REQ):
  - IDLE: (pending | expire) -> REQ.
  - REQ: IACK = 1 -> ACKED, and pending is cleared. An expiry in the same cycle as IACK leaves pending = 1 and is not an overrun.
  - ACKED: IEND = 1 -> ENDWAIT.
  - ENDWAIT: IEND = 0 -> IDLE. If pending is 1, the block proceeds to REQ on the following edge.
- IACK or IEND seen outside the state that consumes it is ignored.
- Latency: IRQ rises on the edge of the expiring tick and falls on the edge that samples IACK = 1.

Optional Feature:
- Macro TIMER_OVERRUN_CNT_EN.
- Defined: an OVR_W-bit saturating counter increments on each overrun, is readable in STATUS[15:8], and is cleared by any STATUS write or by reset.
- Undefined: no counter is built, STATUS[15:8] reads 0, and STATUS writes have no effect.

Decomposition:
- Shared package timer_pkg holds:
  - the FSM state encoding IDLE=0, REQ=1, ACKED=2, ENDWAIT=3;
  - the register address constants;
  - the CTRL bit indices and STATUS field positions.
- One natural sub-module, timer_prescaler, takes EN and PRESCALE and produces the tick pulse.

Test Plan:
- LOAD=3, PRESCALE=0, PERIODIC=1, EN written at edge E0 -> IRQ rises at E3; with immediate one-cycle IACK and IEND pulses, subsequent expiries occur every 3 cycles.
- In REQ, IACK high for 1 cycle -> IRQ 0 on the next edge. IEND high for 2 cycles then low -> busy clears one edge after IEND falls.
- One-shot (PERIODIC=0) LOAD=2, PRESCALE=1 -> exactly one IRQ, 4 cycles after enable; CTRL reads 0x0 afterward and no further IRQ follows.
- LOAD=2, PRESCALE=0, PERIODIC=1, IACK never asserted for 10 cycles -> IRQ held high and STATUS[15:8]=4 with the macro (0 without). A STATUS write then clears it to 0.
- Expiry in the same cycle as IACK -> ACKED with pending=1. After the IEND high/low sequence, IRQ re-asserts one edge after IDLE.
- RESET asserted while in ACKED with pending=1 -> on the next edge IRQ=0, STATUS=0, CTRL=0, and subsequent IEND pulses are ignored.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer interrupt source: FSM encoding,
// register map and bit positions within CTRL/STATUS.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_ACKED   = 2'd2,
    ST_ENDWAIT = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_LOAD     = 2'd0;
  localparam logic [1:0] ADDR_CTRL     = 2'd1;
  localparam logic [1:0] ADDR_PRESCALE = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;

  localparam int unsigned STAT_PENDING = 0;
  localparam int unsigned STAT_BUSY    = 1;
  localparam int unsigned STAT_OVR_LSB = 8;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the timer: counts 0..prescale while enabled and emits a
// one-cycle tick when the count reaches prescale.
module timer_prescaler #(
  parameter int unsigned PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] count;

  assign tick = en && (count == prescale);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/timer_irq_source.sv
// Programmable down-counting timer driving one IRQ/IACK/IEND lane.
// Optional overrun counter in STATUS[15:8] under `TIMER_OVERRUN_CNT_EN.
module timer_irq_source
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PRE_W = 8,
  parameter int unsigned OVR_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             WE,
  input  logic [1:0]       ADDR,
  input  logic [WIDTH-1:0] WDATA,
  output logic [WIDTH-1:0] RDATA,
  output logic             IRQ,
  input  logic             IACK,
  input  logic             IEND
);

  logic [WIDTH-1:0] load_r;
  logic [WIDTH-1:0] cnt;
  logic [PRE_W-1:0] prescale_r;
  logic             en;
  logic             periodic;
  logic             pending;
  logic [OVR_W-1:0] ovr;
  state_t           state;

  logic wr_ctrl;
  logic start;
  logic tick;
  logic expire;
  logic ack;

  assign wr_ctrl = WE && (ADDR == ADDR_CTRL);
  assign start   = wr_ctrl && WDATA[CTRL_EN] && !en;
  assign expire  = tick && (cnt == WIDTH'(1));
  assign ack     = (state == ST_REQ) && IACK;

  timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk      (CLK),
    .reset    (RESET),
    .en       (en),
    .restart  (start),
    .prescale (prescale_r),
    .tick     (tick)
  );

  // Count/expiry is evaluated first so that a CTRL write on the same edge
  // has the final say on EN and PERIODIC.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      load_r     <= '0;
      cnt        <= '0;
      prescale_r <= '0;
      en         <= 1'b0;
      periodic   <= 1'b0;
      pending    <= 1'b0;
    end else begin
      if (WE && (ADDR == ADDR_LOAD))     load_r     <= WDATA;
      if (WE && (ADDR == ADDR_PRESCALE)) prescale_r <= WDATA[PRE_W-1:0];

      if (expire) begin
        if (periodic) begin
          cnt <= load_r;
        end else begin
          cnt <= '0;
          en  <= 1'b0;
        end
      end else if (tick && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (wr_ctrl) begin
        en       <= WDATA[CTRL_EN];
        periodic <= WDATA[CTRL_PERIODIC];
        if (start) cnt <= load_r;
      end

      if (expire)   pending <= 1'b1;
      else if (ack) pending <= 1'b0;
    end
  end

`ifdef TIMER_OVERRUN_CNT_EN
  logic wr_status;
  assign wr_status = WE && (ADDR == ADDR_STATUS);

  // An expiry coinciding with IACK replaces the cleared request, so it is
  // not an overrun.
  always_ff @(posedge CLK) begin
    if (RESET || wr_status) begin
      ovr <= '0;
    end else if (expire && pending && !ack && (ovr != '1)) begin
      ovr <= ovr + 1'b1;
    end
  end
`else
  assign ovr = '0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      IRQ   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending || expire) begin
            state <= ST_REQ;
            IRQ   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (IACK) begin
            state <= ST_ACKED;
            IRQ   <= 1'b0;
          end
        end
        ST_ACKED: begin
          if (IEND) state <= ST_ENDWAIT;
        end
        ST_ENDWAIT: begin
          if (!IEND) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          IRQ   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    RDATA = '0;
    case (ADDR)
      ADDR_LOAD: RDATA = load_r;
      ADDR_CTRL: begin
        RDATA[CTRL_EN]       = en;
        RDATA[CTRL_PERIODIC] = periodic;
      end
      ADDR_PRESCALE: RDATA[PRE_W-1:0] = prescale_r;
      default: begin
        RDATA[STAT_PENDING]         = pending;
        RDATA[STAT_BUSY]            = (state != ST_IDLE);
        RDATA[STAT_OVR_LSB +: OVR_W] = ovr;
      end
    endcase
  end

endmodule
